// File: rtl/instr_fetch_unit.sv
// Instruction fetch / IR stage.
// A fetch request read in IDLE issues one read to a synchronous instruction
// RAM with a fixed latency. The returned word is latched into the IR, and
// en_out pulses for one cycle to tell the downstream control FSM that a new
// instruction is ready. The IR is split into opcode/rd/rs/imm fields for the
// FSM and the datapath.
// Status outputs:
//   busy      - a fetch is in progress.
//   ovr       - sticky flag: a request arrived while busy.
//   fetch_cnt - saturating count of completed fetches.
// RAM_LAT must lie in 1..7 so the latency count fits in three bits.

module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_dout,
  output logic              en_out,
  output logic [15:0]       ir,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        imm,
  output logic              busy,
  output logic              ovr,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a fetch request
    READ = 2'd1,  // read strobe is on the RAM port this cycle
    WAIT = 2'd2   // counting down the RAM latency
  } state_t;

  // Number of WAIT cycles to skip before ram_dout holds the requested word.
  // The READ->WAIT edge is itself the first RAM clock, so the count starts
  // one below the latency.
  localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT - 1);

  state_t     state;
  logic [2:0] lat_cnt;

  // Fetch sequencer. It also owns every registered output, so no path runs
  // from an input straight to an output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      en_out    <= 1'b0;
      ir        <= 16'h0000;
      busy      <= 1'b0;
      ovr       <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values. That lets this default and the capture below overwrite it
      // without a race.
      en_out <= 1'b0;

      case (state)
        IDLE: begin
          // A request held high across several cycles is taken only here.
          // The later edges land in READ/WAIT and count as overruns.
          if (en_in) begin
            state     <= READ;
            ram_rd_en <= 1'b1;
            ram_addr  <= pc_addr;
            busy      <= 1'b1;
          end
        end

        READ: begin
          state     <= WAIT;
          ram_rd_en <= 1'b0;
          lat_cnt   <= LAT_LOAD;
          if (en_in) begin
            ovr <= 1'b1;
          end
        end

        WAIT: begin
          // A request on the capture edge is still an overrun, because the
          // state at that edge is WAIT.
          if (en_in) begin
            ovr <= 1'b1;
          end
          if (lat_cnt == 3'd0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ir     <= ram_dout;
            en_out <= 1'b1;
            if (fetch_cnt != {CNT_W{1'b1}}) begin
              fetch_cnt <= fetch_cnt + 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        default: begin
          state     <= IDLE;
          ram_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Instruction fields are plain slices of the IR. They change only when the
  // IR is loaded.
  assign opcode = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign imm    = ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit.
// Two instances share clock and reset:
//   u1 - RAM_LAT=1, CNT_W=4 (short latency, counter saturation).
//   u3 - RAM_LAT=3, CNT_W=16 (multi-cycle wait).
// Each instance has its own instruction RAM model with the stated latency.
// Off-cycle RAM data is random garbage, so a capture on the wrong edge shows
// up at once.
// The reference model tracks each fetch as a timeline:
//   - accept edge;
//   - capture edge = accept + RAM_LAT + 1;
//   - earliest next accept = accept + RAM_LAT + 2.
// Every output is derived from that timeline.

module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // u1 signals
  logic        en1;
  logic [7:0]  pc1;
  logic        rde1;
  logic [7:0]  addr1;
  logic [15:0] dout1;
  logic        eo1;
  logic [15:0] ir1;
  logic [3:0]  op1;
  logic [1:0]  rd1;
  logic [1:0]  rs1;
  logic [7:0]  imm1;
  logic        busy1;
  logic        ovr1;
  logic [3:0]  cnt1;

  // u3 signals
  logic        en3;
  logic [7:0]  pc3;
  logic        rde3;
  logic [7:0]  addr3;
  logic [15:0] dout3;
  logic        eo3;
  logic [15:0] ir3;
  logic [3:0]  op3;
  logic [1:0]  rd3;
  logic [1:0]  rs3;
  logic [7:0]  imm3;
  logic        busy3;
  logic        ovr3;
  logic [15:0] cnt3;

  instr_fetch_unit #(.ADDR_W(8), .RAM_LAT(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .en_in(en1), .pc_addr(pc1),
    .ram_rd_en(rde1), .ram_addr(addr1), .ram_dout(dout1),
    .en_out(eo1), .ir(ir1), .opcode(op1), .rd(rd1), .rs(rs1), .imm(imm1),
    .busy(busy1), .ovr(ovr1), .fetch_cnt(cnt1)
  );

  instr_fetch_unit #(.ADDR_W(8), .RAM_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .en_in(en3), .pc_addr(pc3),
    .ram_rd_en(rde3), .ram_addr(addr3), .ram_dout(dout3),
    .en_out(eo3), .ir(ir3), .opcode(op3), .rd(rd3), .rs(rs3), .imm(imm3),
    .busy(busy3), .ovr(ovr3), .fetch_cnt(cnt3)
  );

  // Instruction memory shared by both RAM models.
  logic [15:0] mem [256];

  // Latency-1 RAM: data is valid the cycle after the read strobe.
  always @(posedge clk) dout1 <= rde1 ? mem[addr1] : 16'($urandom);

  // Latency-3 RAM: same read, delayed by a two-stage pipeline.
  logic [15:0] pipe3 [3];
  always @(posedge clk) begin
    pipe3[0] <= rde3 ? mem[addr3] : 16'($urandom);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign dout3 = pipe3[2];

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: index 0 = u1, index 1 = u3
  int          lat  [2] = '{1, 3};
  int          cmax [2] = '{15, 65535};
  int          n;
  int          acc_e [2];
  int          cap_e [2];
  int          nxt   [2];
  logic [15:0] cap_d [2];
  logic        e_rde [2];
  logic        e_eo  [2];
  logic        e_busy[2];
  logic        e_ovr [2];
  logic [7:0]  e_addr[2];
  logic [15:0] e_ir  [2];
  int          e_cnt [2];

  task automatic model_reset(input int i);
    acc_e[i]  = -100;
    cap_e[i]  = -100;
    nxt[i]    = -100;
    cap_d[i]  = 16'h0000;
    e_rde[i]  = 1'b0;
    e_eo[i]   = 1'b0;
    e_busy[i] = 1'b0;
    e_ovr[i]  = 1'b0;
    e_addr[i] = 8'h00;
    e_ir[i]   = 16'h0000;
    e_cnt[i]  = 0;
  endtask

  task automatic model_edge(input int i, input logic en, input logic [7:0] pc);
    e_eo[i]  = 1'b0;
    e_rde[i] = 1'b0;
    if (n == cap_e[i]) begin
      e_ir[i] = cap_d[i];
      e_eo[i] = 1'b1;
      if (e_cnt[i] < cmax[i]) e_cnt[i]++;
    end
    if (en) begin
      if (n >= nxt[i]) begin
        acc_e[i]  = n;
        cap_e[i]  = n + lat[i] + 1;
        nxt[i]    = n + lat[i] + 2;
        e_addr[i] = pc;
        cap_d[i]  = mem[pc];
        e_rde[i]  = 1'b1;
      end else begin
        e_ovr[i] = 1'b1;
      end
    end
    e_busy[i] = (n >= acc_e[i]) && (n < cap_e[i]);
  endtask

  task automatic compare_all();
    check("u1.ram_rd_en", 32'(rde1),  32'(e_rde[0]));
    check("u1.ram_addr",  32'(addr1), 32'(e_addr[0]));
    check("u1.en_out",    32'(eo1),   32'(e_eo[0]));
    check("u1.ir",        32'(ir1),   32'(e_ir[0]));
    check("u1.opcode",    32'(op1),   32'(e_ir[0][15:12]));
    check("u1.rd",        32'(rd1),   32'(e_ir[0][11:10]));
    check("u1.rs",        32'(rs1),   32'(e_ir[0][9:8]));
    check("u1.imm",       32'(imm1),  32'(e_ir[0][7:0]));
    check("u1.busy",      32'(busy1), 32'(e_busy[0]));
    check("u1.ovr",       32'(ovr1),  32'(e_ovr[0]));
    check("u1.fetch_cnt", 32'(cnt1),  32'(e_cnt[0]));
    check("u3.ram_rd_en", 32'(rde3),  32'(e_rde[1]));
    check("u3.ram_addr",  32'(addr3), 32'(e_addr[1]));
    check("u3.en_out",    32'(eo3),   32'(e_eo[1]));
    check("u3.ir",        32'(ir3),   32'(e_ir[1]));
    check("u3.opcode",    32'(op3),   32'(e_ir[1][15:12]));
    check("u3.rd",        32'(rd3),   32'(e_ir[1][11:10]));
    check("u3.rs",        32'(rs3),   32'(e_ir[1][9:8]));
    check("u3.imm",       32'(imm3),  32'(e_ir[1][7:0]));
    check("u3.busy",      32'(busy3), 32'(e_busy[1]));
    check("u3.ovr",       32'(ovr3),  32'(e_ovr[1]));
    check("u3.fetch_cnt", 32'(cnt3),  32'(e_cnt[1]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".u1.ram_rd_en"}, 32'(rde1), 0);
    check({tag, ".u1.ram_addr"},  32'(addr1), 0);
    check({tag, ".u1.en_out"},    32'(eo1), 0);
    check({tag, ".u1.ir"},        32'(ir1), 0);
    check({tag, ".u1.fields"},    32'({op1, rd1, rs1, imm1}), 0);
    check({tag, ".u1.busy"},      32'(busy1), 0);
    check({tag, ".u1.ovr"},       32'(ovr1), 0);
    check({tag, ".u1.fetch_cnt"}, 32'(cnt1), 0);
    check({tag, ".u3.ram_rd_en"}, 32'(rde3), 0);
    check({tag, ".u3.ram_addr"},  32'(addr3), 0);
    check({tag, ".u3.en_out"},    32'(eo3), 0);
    check({tag, ".u3.ir"},        32'(ir3), 0);
    check({tag, ".u3.fields"},    32'({op3, rd3, rs3, imm3}), 0);
    check({tag, ".u3.busy"},      32'(busy3), 0);
    check({tag, ".u3.ovr"},       32'(ovr3), 0);
    check({tag, ".u3.fetch_cnt"}, 32'(cnt3), 0);
  endtask

  // One clock: drive inputs away from the edge, advance the model at the
  // edge, then compare 1 time unit later.
  task automatic cycle(input logic a_en1, input logic [7:0] a_pc1,
                       input logic a_en3, input logic [7:0] a_pc3);
    en1 = a_en1;
    pc1 = a_pc1;
    en3 = a_en3;
    pc3 = a_pc3;
    @(posedge clk);
    n++;
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, a_en1, a_pc1);
      model_edge(1, a_en3, a_pc3);
    end
    #1;
    compare_all();
  endtask

  // Table of single-fetch vectors with hand-decoded expected fields
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  initial begin
    int cnt_rd;
    int cnt_eo;
    int eo_edge;
    int cnt_busy;
    int w;
    logic got;

    vec[0] = '{8'h05, 16'h2A5C, 4'h2, 2'b10, 2'b10, 8'h5C};
    vec[1] = '{8'h00, 16'h0000, 4'h0, 2'b00, 2'b00, 8'h00};
    vec[2] = '{8'hFF, 16'hFFFF, 4'hF, 2'b11, 2'b11, 8'hFF};
    vec[3] = '{8'h80, 16'hB003, 4'hB, 2'b00, 2'b00, 8'h03};
    vec[4] = '{8'h3C, 16'h79E1, 4'h7, 2'b10, 2'b01, 8'hE1};
    vec[5] = '{8'h11, 16'hC65A, 4'hC, 2'b01, 2'b10, 8'h5A};

    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int k = 0; k < NV; k++) mem[vec[k].pc] = vec[k].data;

    n = 0;
    model_reset(0);
    model_reset(1);
    rst = 1'b0;
    en1 = 1'b0; pc1 = 8'h00;
    en3 = 1'b0; pc3 = 8'h00;

    // Power-on reset
    cycle(1'b1, 8'h05, 1'b1, 8'h05);
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    check_zero("por");
    rst = 1'b1;

    // Single fetch from pc 05 on both instances
    cnt_rd = 0; eo_edge = -1; cnt_busy = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(k == 0, 8'h05, k == 0, 8'h05);
      if (k == 0) begin
        check("single.u1.rd_en_E0", 32'(rde1), 1);
        check("single.u1.addr_E0",  32'(addr1), 32'h05);
      end
      if (k == 1) begin
        check("single.u1.rd_en_E1",  32'(rde1), 0);
        check("single.u1.en_out_E1", 32'(eo1), 0);
      end
      if (k == 2) begin
        check("single.u1.en_out_E2", 32'(eo1), 1);
        check("single.u1.ir",        32'(ir1), 32'h2A5C);
        check("single.u1.opcode",    32'(op1), 32'h2);
        check("single.u1.rd",        32'(rd1), 32'h2);
        check("single.u1.rs",        32'(rs1), 32'h2);
        check("single.u1.imm",       32'(imm1), 32'h5C);
        check("single.u1.fetch_cnt", 32'(cnt1), 1);
      end
      if (k == 3) begin
        check("single.u1.en_out_E3", 32'(eo1), 0);
        check("single.u1.ir_hold",   32'(ir1), 32'h2A5C);
        check("lat3.busy_E3",        32'(busy3), 1);
      end
      if (k == 4) begin
        check("lat3.busy_E4", 32'(busy3), 0);
        check("lat3.ir",      32'(ir3), 32'h2A5C);
      end
      cnt_rd += int'(rde3);
      if (busy3) cnt_busy++;
      if (eo3 && eo_edge < 0) eo_edge = k;
    end
    check("lat3.rd_en_cycles", 32'(cnt_rd), 1);
    check("lat3.en_out_edge",  32'(eo_edge), 4);
    check("lat3.busy_cycles",  32'(cnt_busy), 4);

    // Overrun: second request one cycle after the first (u1)
    cnt_rd = 0; cnt_eo = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(k < 2, 8'h11, 1'b0, 8'h00);
      cnt_rd += int'(rde1);
      cnt_eo += int'(eo1);
      if (k == 2) check("ovr.set_E2", 32'(ovr1), 1);
    end
    check("ovr.rd_en_cycles", 32'(cnt_rd), 1);
    check("ovr.en_out_pulses", 32'(cnt_eo), 1);
    check("ovr.sticky", 32'(ovr1), 1);
    check("ovr.other_clear", 32'(ovr3), 0);

    // Table-driven fetches on u1
    for (int k = 0; k < NV; k++) begin
      cycle(1'b1, vec[k].pc, 1'b0, 8'h00);
      got = 1'b0;
      w = 0;
      while (!got && w < 8) begin
        cycle(1'b0, 8'h00, 1'b0, 8'h00);
        got = eo1;
        w++;
      end
      check("tbl.en_out_seen", 32'(got), 1);
      check("tbl.ir",     32'(ir1),  32'(vec[k].data));
      check("tbl.opcode", 32'(op1),  32'(vec[k].op));
      check("tbl.rd",     32'(rd1),  32'(vec[k].rd));
      check("tbl.rs",     32'(rs1),  32'(vec[k].rs));
      check("tbl.imm",    32'(imm1), 32'(vec[k].imm));
    end

    // Reset in the middle of a u3 fetch, then a clean fetch of B003
    cycle(1'b0, 8'h00, 1'b1, 8'h3C);
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    check("midrst.pre_busy", 32'(busy3), 1);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b1;
    cnt_eo = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
      cnt_eo += int'(eo3) + int'(eo1);
    end
    check("midrst.no_stale_en_out", 32'(cnt_eo), 0);
    cycle(1'b0, 8'h00, 1'b1, 8'h80);
    got = 1'b0;
    w = 0;
    while (!got && w < 8) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
      got = eo3;
      w++;
    end
    check("midrst.en_out_seen", 32'(got), 1);
    check("midrst.ir", 32'(ir3), 32'hB003);
    check("midrst.fetch_cnt", 32'(cnt3), 1);
    check("midrst.ovr", 32'(ovr3), 0);

    // Back-to-back fetches: counter saturation on u1 (CNT_W=4)
    cnt_eo = 0;
    for (int r = 0; r < 17; r++) begin
      cycle(1'b1, 8'(r), 1'b0, 8'h00);
      got = 1'b0;
      w = 0;
      while (!got && w < 8) begin
        cycle(1'b0, 8'h00, 1'b0, 8'h00);
        got = eo1;
        w++;
      end
      cnt_eo += int'(got);
      if (r == 14) check("sat.cnt_at_15", 32'(cnt1), 32'hF);
    end
    check("sat.pulses", 32'(cnt_eo), 17);
    check("sat.fetch_cnt", 32'(cnt1), 32'hF);
    check("sat.ovr", 32'(ovr1), 0);

    // Randomized traffic against the model, with occasional async resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        #1;
        check_zero("rnd_rst");
        cycle(1'b0, 8'h00, 1'b0, 8'h00);
        rst = 1'b1;
      end
      cycle($urandom_range(0, 9) < 3, 8'($urandom),
            $urandom_range(0, 9) < 3, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
